// File: rtl/bwt_pkg.sv
// Shared types and defaults for the BWT prefix-doubling blocks.
package bwt_pkg;

  localparam int unsigned STRING_LEN_DEF = 8;
  localparam int unsigned KEY_W_DEF      = 8;
  localparam int unsigned IDX_W_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // key0 sits in the upper half, so a plain vector compare is lexicographic.
  typedef struct packed {
    logic [KEY_W_DEF-1:0] key0;
    logic [KEY_W_DEF-1:0] key1;
  } key_tuple_t;

endpackage

// File: rtl/tuple_compare.sv
// Lexicographic comparison of the current (key0,key1) tuple against the previous one.
module tuple_compare #(
  parameter int unsigned KEY_W = 8
) (
  input  logic [KEY_W-1:0] cur_key0,
  input  logic [KEY_W-1:0] cur_key1,
  input  logic [KEY_W-1:0] prev_key0,
  input  logic [KEY_W-1:0] prev_key1,
  output logic             neq,
  output logic             lt
);

  logic [2*KEY_W-1:0] w_cur;
  logic [2*KEY_W-1:0] w_prev;

  // key0 is the major key, so the concatenation orders lexicographically
  always_comb begin
    w_cur  = {cur_key0, cur_key1};
    w_prev = {prev_key0, prev_key1};
    neq    = (w_cur != w_prev);
    lt     = (w_cur < w_prev);
  end

endmodule

// File: rtl/bucket_ranker.sv
// Bucket ranker: assigns dense ranks to a sorted stream of (key0,key1) tuples and scatters
// them to ranks[] by original string position. Optional output all_unique is enabled by
// defining BUCKET_RANKER_UNIQUE_EN.
module bucket_ranker
  import bwt_pkg::*;
#(
  parameter int unsigned STRING_LEN = STRING_LEN_DEF,
  parameter int unsigned KEY_W      = KEY_W_DEF,
  parameter int unsigned IDX_W      = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] in_key0,
  input  logic [KEY_W-1:0] in_key1,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic [KEY_W-1:0] ranks [0:STRING_LEN-1],
  output logic [KEY_W-1:0] max_bucket,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef BUCKET_RANKER_UNIQUE_EN
  ,
  output logic             all_unique
`endif
);

  localparam int unsigned CNT_W = $clog2(STRING_LEN + 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_count;
  logic [KEY_W-1:0] r_prev_key0;
  logic [KEY_W-1:0] r_prev_key1;
  logic [KEY_W-1:0] r_max;
  logic [KEY_W-1:0] r_ranks [0:STRING_LEN-1];
  logic             r_err;

  logic             w_accept;
  logic             w_first;
  logic             w_last_slot;
  logic             w_neq;
  logic             w_lt;
  logic [KEY_W-1:0] w_rank;
  logic             w_ovf;
  logic             w_idx_bad;
  logic             w_unsorted;
  logic             w_last_bad;

  tuple_compare #(
    .KEY_W (KEY_W)
  ) u_cmp (
    .cur_key0  (in_key0),
    .cur_key1  (in_key1),
    .prev_key0 (r_prev_key0),
    .prev_key1 (r_prev_key1),
    .neq       (w_neq),
    .lt        (w_lt)
  );

  // Handshake, pass position and per-tuple error conditions
  always_comb begin
    in_ready    = (r_state == ST_RUN);
    w_accept    = in_valid && in_ready;
    w_first     = (r_count == '0);
    w_last_slot = (32'(r_count) == STRING_LEN - 1);
    w_idx_bad   = (32'(in_idx) >= STRING_LEN);
    w_unsorted  = !w_first && w_lt;
    w_last_bad  = (in_last != w_last_slot);
  end

  // Dense rank: first tuple is 1, a key change bumps it, saturating at all-ones
  always_comb begin
    w_rank = r_max;
    w_ovf  = 1'b0;
    if (w_first) begin
      w_rank = KEY_W'(1);
    end else if (w_neq) begin
      if (r_max == {KEY_W{1'b1}}) begin
        w_ovf = 1'b1;
      end else begin
        w_rank = r_max + KEY_W'(1);
      end
    end
  end

  // Pass FSM, rank scatter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_prev_key0 <= '0;
      r_prev_key1 <= '0;
      r_max       <= '0;
      r_err       <= 1'b0;
      for (int unsigned i = 0; i < STRING_LEN; i++) begin
        r_ranks[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_count     <= '0;
            r_prev_key0 <= '0;
            r_prev_key1 <= '0;
            r_max       <= '0;
            r_err       <= 1'b0;
            for (int unsigned i = 0; i < STRING_LEN; i++) begin
              r_ranks[i] <= '0;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_count     <= r_count + CNT_W'(1);
            r_prev_key0 <= in_key0;
            r_prev_key1 <= in_key1;
            r_max       <= w_rank;
            for (int unsigned i = 0; i < STRING_LEN; i++) begin
              if (!w_idx_bad && (32'(in_idx) == i)) begin
                r_ranks[i] <= w_rank;
              end
            end
            if (w_idx_bad || w_unsorted || w_last_bad || w_ovf) begin
              r_err <= 1'b1;
            end
            // End of pass is decided by count alone; in_last is only checked
            if (w_last_slot) begin
              r_state <= ST_FINISH;
            end
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs
  always_comb begin
    busy       = (r_state != ST_IDLE);
    done       = (r_state == ST_FINISH);
    err        = r_err;
    max_bucket = r_max;
    ranks      = r_ranks;
  end

`ifdef BUCKET_RANKER_UNIQUE_EN
  // Every position got its own bucket, so prefix doubling can stop
  always_comb begin
    all_unique = (32'(r_max) == STRING_LEN);
  end
`endif

endmodule

// File: tb/tb_bucket_ranker.sv
// Self-checking bench for bucket_ranker: directed scenarios plus randomized passes
// compared against a behavioural ranking model.
module tb_bucket_ranker;
  import bwt_pkg::*;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_key0 = '0;
  logic [7:0] in_key1 = '0;
  logic [7:0] in_idx = '0;
  logic       in_ready;
  logic [7:0] ranks [0:N-1];
  logic [7:0] max_bucket;
  logic       busy;
  logic       done;
  logic       err;
`ifdef BUCKET_RANKER_UNIQUE_EN
  logic       all_unique;
`endif

  bucket_ranker #(
    .STRING_LEN (N),
    .KEY_W      (8),
    .IDX_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key0    (in_key0),
    .in_key1    (in_key1),
    .in_idx     (in_idx),
    .in_last    (in_last),
    .ranks      (ranks),
    .max_bucket (max_bucket),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef BUCKET_RANKER_UNIQUE_EN
    ,
    .all_unique (all_unique)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int done_total = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_total++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus for one pass and the expected outcome
  key_tuple_t t_key [N];
  logic [7:0] t_idx [N];
  logic       t_last [N];
  logic [7:0] exp_rank [N];
  int         exp_max;
  logic       exp_err;

  task automatic set_t(input int i, input int k0, input int k1, input int idx);
    t_key[i].key0 = 8'(k0);
    t_key[i].key1 = 8'(k1);
    t_idx[i]      = 8'(idx);
    t_last[i]     = (i == N - 1);
  endtask

  task automatic load_ref_pass();
    set_t(0, 1, 1, 7); set_t(1, 1, 2, 6); set_t(2, 1, 2, 5); set_t(3, 2, 0, 4);
    set_t(4, 3, 1, 3); set_t(5, 3, 1, 2); set_t(6, 4, 0, 1); set_t(7, 5, 5, 0);
  endtask

  // Rank = 1 + number of key changes seen so far; errors from the pass rules
  task automatic model();
    int r;
    r = 0;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) exp_rank[i] = '0;
    for (int i = 0; i < N; i++) begin
      if (i == 0) r = 1;
      else if (t_key[i] != t_key[i-1]) begin
        if (r == 255) exp_err = 1'b1;
        else r = r + 1;
      end
      if (i > 0 && t_key[i] < t_key[i-1]) exp_err = 1'b1;
      if (t_idx[i] >= 8'(N)) exp_err = 1'b1;
      else exp_rank[t_idx[i]] = r[7:0];
      if (t_last[i] != (i == N - 1)) exp_err = 1'b1;
    end
    exp_max = r;
  endtask

  task automatic present(input int i);
    in_key0 = t_key[i].key0;
    in_key1 = t_key[i].key1;
    in_idx  = t_idx[i];
    in_last = t_last[i];
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int i);
    present(i);
    in_valid = 1'b1;
    for (int w = 0; w < 20 && in_ready !== 1'b1; w++) @(negedge clk);
    check("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_pass(input string name, input int gap, input int abort_after);
    int d0;
    d0 = done_total;
    model();
    // First tuple is already valid alongside start; it must not be taken that cycle
    present(0);
    in_valid = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_run"}, busy, 1);
    for (int i = 0; i < N; i++) begin
      if (abort_after == i) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({name, "_abort_ready"}, in_ready, 0);
        check({name, "_abort_busy"}, busy, 0);
        check({name, "_abort_max"}, max_bucket, 0);
        check({name, "_abort_err"}, err, 0);
        for (int k = 0; k < N; k++) check($sformatf("%s_abort_rank%0d", name, k), ranks[k], 0);
        repeat (3) @(negedge clk);
        check({name, "_abort_nodone"}, done_total - d0, 0);
        return;
      end
      if (i == 3) start = 1'b1;
      send(i);
      start = 1'b0;
      if (gap != 0 && i < N - 1) @(negedge clk);
    end
    check({name, "_done_pulse"}, done, 1);
    check({name, "_busy_finish"}, busy, 1);
    check({name, "_ready_finish"}, in_ready, 0);
`ifdef BUCKET_RANKER_UNIQUE_EN
    check({name, "_all_unique"}, all_unique, (exp_max == N) ? 1 : 0);
`endif
    @(negedge clk);
    check({name, "_done_low"}, done, 0);
    check({name, "_busy_idle"}, busy, 0);
    repeat (2) @(negedge clk);
    check({name, "_done_count"}, done_total - d0, 1);
    check({name, "_max"}, max_bucket, exp_max);
    check({name, "_err"}, err, exp_err);
    for (int k = 0; k < N; k++) check($sformatf("%s_rank%0d", name, k), ranks[k], exp_rank[k]);
  endtask

  task automatic gen_random();
    key_tuple_t tmp;
    int j;
    for (int i = 0; i < N; i++) begin
      t_key[i].key0 = 8'($urandom_range(0, 3));
      t_key[i].key1 = 8'($urandom_range(0, 3));
      t_idx[i]      = 8'(i);
      t_last[i]     = (i == N - 1);
    end
    for (int i = 1; i < N; i++) begin
      for (int k = i; k > 0 && t_key[k] < t_key[k-1]; k--) begin
        tmp = t_key[k]; t_key[k] = t_key[k-1]; t_key[k-1] = tmp;
      end
    end
    for (int i = N - 1; i > 0; i--) begin
      logic [7:0] s;
      j = int'($urandom_range(0, i));
      s = t_idx[i]; t_idx[i] = t_idx[j]; t_idx[j] = s;
    end
    case ($urandom_range(0, 3))
      1: t_idx[$urandom_range(0, N - 1)] = 8'(8 + $urandom_range(0, 200));
      2: begin
        j = int'($urandom_range(0, N - 2));
        tmp = t_key[j]; t_key[j] = t_key[j+1]; t_key[j+1] = tmp;
      end
      3: begin
        j = int'($urandom_range(0, N - 1));
        t_last[j] = ~t_last[j];
      end
      default: ;
    endcase
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_max", max_bucket, 0);
    for (int k = 0; k < N; k++) check($sformatf("rst_rank%0d", k), ranks[k], 0);

    load_ref_pass();
    run_pass("sorted", 0, -1);
    check("sorted_max_const", max_bucket, 6);
    check("sorted_rank7_const", ranks[7], 1);
    check("sorted_rank0_const", ranks[0], 6);

    run_pass("gapped", 1, -1);

    for (int i = 0; i < N; i++) set_t(i, i, 7 - i, i);
    run_pass("distinct", 0, -1);
    check("distinct_max_const", max_bucket, 8);

    load_ref_pass();
    t_idx[2] = 8'd9;
    run_pass("bad_idx", 0, -1);
    check("bad_idx_err_const", err, 1);

    load_ref_pass();
    run_pass("abort", 0, 4);
    run_pass("after_abort", 0, -1);

    load_ref_pass();
    t_key[4].key0 = 8'd1;
    t_key[4].key1 = 8'd0;
    run_pass("unsorted", 0, -1);

    load_ref_pass();
    t_last[5] = 1'b1;
    run_pass("early_last", 1, -1);

    for (int p = 0; p < 20; p++) begin
      gen_random();
      run_pass($sformatf("rand%0d", p), int'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
